// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
// Produces the 5-bit frame index for the LED pattern decoder. A 24-bit
// prescaler divides clk by DIV to make a frame step. On each step the index
// moves through 0..last in loop, ping-pong or one-shot order, or is held in
// freeze mode.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   run      1 = prescaler counts and frames advance, 0 = everything holds
//   dir      loop mode direction (0 = up, 1 = down)
//   mode     0 = loop, 1 = ping-pong, 2 = one-shot, 3 = freeze
//   last     highest frame index of the sequence
//   restart  single-cycle synchronous restart request
//   frame    registered frame index
//   tick     one-cycle pulse on the first cycle of each new frame value
//   done     one-shot sequence finished, held until restart or reset
module led_frame_sequencer #(
  parameter int unsigned DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic [1:0] mode,
  input  logic [4:0] last,
  input  logic       restart,
  output logic [4:0] frame,
  output logic       tick,
  output logic       done
);

  localparam logic [23:0] CNT_MAX     = 24'(DIV - 1);
  localparam logic [1:0]  MODE_LOOP   = 2'd0;
  localparam logic [1:0]  MODE_PING   = 2'd1;
  localparam logic [1:0]  MODE_ONCE   = 2'd2;
  localparam logic [1:0]  MODE_FREEZE = 2'd3;

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [4:0]  r_frame;
  logic        r_tick;
  logic        r_done;

  logic [4:0]  w_next_frame;
  state_t      w_next_state;
  logic        w_enter_done;

  assign frame = r_frame;
  assign tick  = r_tick;
  assign done  = r_done;

  // Frame index and direction state that the next step would produce.
  always_comb begin
    w_next_frame = r_frame;
    w_next_state = r_state;
    w_enter_done = 1'b0;
    if (mode == MODE_FREEZE) begin
      // Step is consumed but the index stays where it is.
      w_next_frame = r_frame;
    end else if (r_frame > last) begin
      // last was lowered below the current index: restart from the bottom.
      w_next_frame = 5'd0;
      w_next_state = ST_UP;
    end else begin
      case (mode)
        MODE_LOOP: begin
          // Loop ignores the FSM direction and follows dir only.
          if (dir == 1'b0) begin
            w_next_frame = (r_frame == last) ? 5'd0 : r_frame + 5'd1;
          end else begin
            w_next_frame = (r_frame == 5'd0) ? last : r_frame - 5'd1;
          end
        end
        MODE_PING: begin
          if (r_state == ST_DOWN) begin
            if (r_frame != 5'd0) begin
              w_next_frame = r_frame - 5'd1;
            end else begin
              w_next_frame = (last == 5'd0) ? 5'd0 : 5'd1;
              w_next_state = ST_UP;
            end
          end else begin
            if (r_frame < last) begin
              w_next_frame = r_frame + 5'd1;
            end else if (last != 5'd0) begin
              w_next_frame = r_frame - 5'd1;
              w_next_state = ST_DOWN;
            end else begin
              // Single-frame sequence: stay on 0 heading up.
              w_next_frame = 5'd0;
            end
          end
        end
        MODE_ONCE: begin
          if (r_frame < last) begin
            w_next_frame = r_frame + 5'd1;
          end else begin
            w_next_state = ST_DONE;
            w_enter_done = 1'b1;
          end
        end
        default: begin
          w_next_frame = r_frame;
        end
      endcase
    end
  end

  // Prescaler, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 24'd0;
      r_frame <= 5'd0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ST_UP;
    end else if (restart) begin
      // Restart wins over a step landing on the same edge.
      r_cnt   <= 24'd0;
      r_frame <= ((mode == MODE_LOOP) && dir) ? last : 5'd0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ST_UP;
    end else begin
      r_tick <= 1'b0;
      // DONE freezes the prescaler, so no further tick can appear.
      if (run && (r_state != ST_DONE)) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt   <= 24'd0;
          r_frame <= w_next_frame;
          r_state <= w_next_state;
          r_tick  <= 1'b1;
          if (w_enter_done) begin
            r_done <= 1'b1;
          end else begin
            r_done <= r_done;
          end
        end else begin
          r_cnt <= r_cnt + 24'd1;
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer
// Directed bench for led_frame_sequencer with DIV = 4. A behavioural model
// tracks elapsed run cycles, the frame index, a ping-pong heading and a
// finished flag; it is advanced on every rising edge from the same inputs
// the DUT sees, and outputs are compared on every falling edge. Literal
// expectations at fixed points pin the model itself.
module tb_led_frame_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       dir;
  logic [1:0] mode;
  logic [4:0] last;
  logic       restart;
  logic [4:0] frame;
  logic       tick;
  logic       done;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_cnt   = 0;
  int m_frame = 0;
  bit m_up    = 1'b1;
  bit m_tick  = 1'b0;
  bit m_done  = 1'b0;

  led_frame_sequencer #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .dir     (dir),
    .mode    (mode),
    .last    (last),
    .restart (restart),
    .frame   (frame),
    .tick    (tick),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one frame step to the model.
  task automatic model_step();
    int l;
    l = int'(last);
    if (mode == 2'd3) begin
      m_frame = m_frame;
    end else if (m_frame > l) begin
      m_frame = 0;
      m_up = 1'b1;
    end else if (mode == 2'd0) begin
      if (!dir) m_frame = (m_frame == l) ? 0 : m_frame + 1;
      else      m_frame = (m_frame == 0) ? l : m_frame - 1;
    end else if (mode == 2'd1) begin
      if (l == 0) begin
        m_frame = 0;
        m_up = 1'b1;
      end else if (m_up) begin
        if (m_frame == l) begin m_frame = l - 1; m_up = 1'b0; end
        else m_frame = m_frame + 1;
      end else begin
        if (m_frame == 0) begin m_frame = 1; m_up = 1'b1; end
        else m_frame = m_frame - 1;
      end
    end else begin
      if (m_frame < l) m_frame = m_frame + 1;
      else m_done = 1'b1;
    end
  endtask

  // Model reaction to one rising edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0; m_frame = 0; m_tick = 1'b0; m_done = 1'b0; m_up = 1'b1;
    end else if (restart) begin
      m_cnt = 0; m_tick = 1'b0; m_done = 1'b0; m_up = 1'b1;
      m_frame = ((mode == 2'd0) && dir) ? int'(last) : 0;
    end else begin
      m_tick = 1'b0;
      if (run && !m_done) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DIV) begin
          m_cnt = 0;
          m_tick = 1'b1;
          model_step();
        end
      end
    end
  endtask

  // Compare process: advance the model at each rising edge, check at the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("model_frame", {27'd0, frame}, m_frame);
      check("model_tick", {31'd0, tick}, {31'd0, m_tick});
      check("model_done", {31'd0, done}, {31'd0, m_done});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    rst_n = 1'b0; run = 1'b1; dir = 1'b0; mode = 2'd0; last = 5'd3; restart = 1'b0;
    cyc(2);
    check("reset_frame", {27'd0, frame}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    // Loop up, last=3
    cyc(4);
    check("loopup_first_frame", {27'd0, frame}, 32'd1);
    check("loopup_first_tick", {31'd0, tick}, 32'd1);
    cyc(1);
    check("loopup_tick_low", {31'd0, tick}, 32'd0);
    cyc(11);
    check("loopup_wrap", {27'd0, frame}, 32'd0);
    cyc(6);
    // Reset mid-sequence, then loop down with last=5
    rst_n = 1'b0; dir = 1'b1; last = 5'd5;
    cyc(1);
    check("midreset_frame", {27'd0, frame}, 32'd0);
    rst_n = 1'b1;
    cyc(4);
    check("loopdn_first", {27'd0, frame}, 32'd5);
    cyc(4);
    check("loopdn_second", {27'd0, frame}, 32'd4);
    cyc(2);
    run = 1'b0;
    cyc(7);
    check("pause_hold", {27'd0, frame}, 32'd4);
    run = 1'b1;
    cyc(1);
    check("resume_partial", {27'd0, frame}, 32'd4);
    cyc(1);
    check("resume_step", {27'd0, frame}, 32'd3);
    cyc(8);
    // Ping-pong, last=3
    mode = 2'd1; dir = 1'b0; last = 5'd3; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("pp_restart", {27'd0, frame}, 32'd0);
    cyc(12);
    check("pp_top", {27'd0, frame}, 32'd3);
    cyc(4);
    check("pp_turn", {27'd0, frame}, 32'd2);
    cyc(8);
    check("pp_bottom", {27'd0, frame}, 32'd0);
    cyc(4);
    check("pp_up_again", {27'd0, frame}, 32'd1);
    cyc(8);
    // Ping-pong with a single frame
    restart = 1'b1; last = 5'd0;
    cyc(1);
    restart = 1'b0;
    cyc(4);
    check("pp0_frame", {27'd0, frame}, 32'd0);
    check("pp0_tick", {31'd0, tick}, 32'd1);
    cyc(8);
    // Freeze
    mode = 2'd3; last = 5'd7;
    cyc(12);
    // One-shot, last=2
    mode = 2'd2; last = 5'd2; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    cyc(8);
    check("once_top", {27'd0, frame}, 32'd2);
    check("once_not_done", {31'd0, done}, 32'd0);
    cyc(4);
    check("once_done", {31'd0, done}, 32'd1);
    check("once_final_tick", {31'd0, tick}, 32'd1);
    cyc(1);
    check("once_tick_off", {31'd0, tick}, 32'd0);
    mode = 2'd0;
    cyc(12);
    check("done_held_frame", {27'd0, frame}, 32'd2);
    check("done_held", {31'd0, done}, 32'd1);
    mode = 2'd2; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("once_restart_frame", {27'd0, frame}, 32'd0);
    check("once_restart_done", {31'd0, done}, 32'd0);
    cyc(4);
    check("once_restart_step", {27'd0, frame}, 32'd1);
    // Out-of-range after lowering last
    mode = 2'd0; dir = 1'b0; last = 5'd31; restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    cyc(80);
    check("oor_at20", {27'd0, frame}, 32'd20);
    last = 5'd10;
    cyc(4);
    check("oor_to0", {27'd0, frame}, 32'd0);
    check("oor_tick", {31'd0, tick}, 32'd1);
    // Restart on the same edge as a step
    cyc(7);
    check("coinc_before", {27'd0, frame}, 32'd1);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("coinc_frame", {27'd0, frame}, 32'd0);
    check("coinc_tick", {31'd0, tick}, 32'd0);
    cyc(4);
    check("coinc_next", {27'd0, frame}, 32'd1);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
